// File: rtl/hazard_pkg.sv
// Shared types for the hazard detection unit: stall FSM state, the
// destination-register tag carried down the pipe, and the x0 constant.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hazard_state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic       RegWrite;
        logic       MemRead;
    } pipe_tag_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when an instruction that reads 'rs' depends on the tagged producer.
    function automatic logic reads_tag(input logic uses, input logic [4:0] rs,
                                       input pipe_tag_t tag);
        return uses && (tag.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating event counters for stall, flush and freeze cycles.
// Only instantiated when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             freeze_i,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o,
    output logic [CNT_W-1:0] freeze_cycles_o
);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] freeze_q, freeze_d;

    // Increment on each flagged cycle, sticking at all-ones.
    always_comb begin
        stall_d  = stall_q;
        flush_d  = flush_q;
        freeze_d = freeze_q;
        if (stall_i  && (stall_q  != '1)) stall_d  = stall_q  + 1'b1;
        if (flush_i  && (flush_q  != '1)) flush_d  = flush_q  + 1'b1;
        if (freeze_i && (freeze_q != '1)) freeze_d = freeze_q + 1'b1;
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q  <= '0;
            flush_q  <= '0;
            freeze_q <= '0;
        end else begin
            stall_q  <= stall_d;
            flush_q  <= flush_d;
            freeze_q <= freeze_d;
        end
    end

    assign stall_cycles_o  = stall_q;
    assign flush_count_o   = flush_q;
    assign freeze_cycles_o = freeze_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Hazard detection for the 5-stage pipeline: tracks rd/RegWrite/MemRead
// through ID/EX, EX/MEM and MEM/WB and generates stall, flush, bubble and
// freeze controls for load-use, data-memory wait and taken branches.
// Optional performance counters are enabled with HAZARD_PERF_CNT_EN.
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] IFID_rs1,
    input  logic [4:0] IFID_rs2,
    input  logic       ID_uses_rs1,
    input  logic       ID_uses_rs2,
    input  logic [4:0] ID_rd,
    input  logic       ID_RegWrite,
    input  logic       ID_MemRead,
    input  logic       EX_branch_taken,
    input  logic       mem_ready,
    input  logic       EXMEM_MemAccess,
    output logic       PC_Write,
    output logic       IFID_Write,
    output logic       IFID_Flush,
    output logic       IDEX_Bubble,
    output logic       Pipe_Freeze,
    output logic [4:0] IDEX_rd,
    output logic [4:0] EXMEM_rd,
    output logic [4:0] MEM_WB_rd,
    output logic       IDEX_RegWrite,
    output logic       EXMEM_RegWrite,
    output logic       MEM_WB_RegWrite,
    output logic       IDEX_MemRead
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] freeze_cycles
`endif
);

    // The first bubble is issued from RUN, so LU_STALL covers the rest.
    localparam logic [2:0] LU_CNT_INIT =
        (LOAD_USE_CYCLES > 1) ? 3'(LOAD_USE_CYCLES - 2) : 3'd0;

    hazard_state_e state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    pipe_tag_t     idex_q, idex_d;
    pipe_tag_t     exmem_q, exmem_d;
    pipe_tag_t     memwb_q, memwb_d;

    logic load_use;
    logic mem_wait;
    logic stall_active;

    assign load_use = idex_q.MemRead && idex_q.RegWrite && (idex_q.rd != REG_ZERO) &&
                      (reads_tag(ID_uses_rs1, IFID_rs1, idex_q) ||
                       reads_tag(ID_uses_rs2, IFID_rs2, idex_q));
    assign mem_wait     = EXMEM_MemAccess && !mem_ready;
    assign stall_active = (state_q == LU_STALL) || load_use;

    // Mealy pipeline controls, prioritised; all held low while in reset.
    always_comb begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        Pipe_Freeze = 1'b0;
        if (rst_n) begin
            if (mem_wait) begin
                Pipe_Freeze = 1'b1;
            end else if (EX_branch_taken) begin
                // IF/ID must load so that the NOP actually replaces the fetch.
                PC_Write    = 1'b1;
                IFID_Write  = 1'b1;
                IFID_Flush  = 1'b1;
                IDEX_Bubble = 1'b1;
            end else if (stall_active) begin
                IDEX_Bubble = 1'b1;
            end else begin
                PC_Write   = 1'b1;
                IFID_Write = 1'b1;
            end
        end
    end

    // Load-use stall sequencing: freeze holds, branch aborts, else count bubbles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mem_wait) begin
            state_d = state_q;
        end else if (EX_branch_taken) begin
            state_d = RUN;
            cnt_d   = 3'd0;
        end else if (state_q == LU_STALL) begin
            if (cnt_q == 3'd0) begin
                state_d = RUN;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end else if (load_use && (LOAD_USE_CYCLES > 1)) begin
            state_d = LU_STALL;
            cnt_d   = LU_CNT_INIT;
        end
    end

    // Next values of the tracked destination tags.
    always_comb begin
        idex_d  = idex_q;
        exmem_d = exmem_q;
        memwb_d = '0;
        if (!Pipe_Freeze) begin
            memwb_d = exmem_q;
            exmem_d = idex_q;
            if (IDEX_Bubble) begin
                idex_d = '0;
            end else begin
                idex_d.rd       = ID_rd;
                idex_d.RegWrite = ID_RegWrite;
                idex_d.MemRead  = ID_MemRead;
            end
        end
    end

    // State, counter and tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign IDEX_rd         = idex_q.rd;
    assign IDEX_RegWrite   = idex_q.RegWrite;
    assign IDEX_MemRead    = idex_q.MemRead;
    assign EXMEM_rd        = exmem_q.rd;
    assign EXMEM_RegWrite  = exmem_q.RegWrite;
    assign MEM_WB_rd       = memwb_q.rd;
    assign MEM_WB_RegWrite = memwb_q.RegWrite;

    // EX/MEM and MEM/WB MemRead are carried for struct uniformity only.
    logic unused_memread;
    assign unused_memread = exmem_q.MemRead ^ memwb_q.MemRead;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .stall_i         (IDEX_Bubble && !IFID_Flush),
        .flush_i         (IFID_Flush),
        .freeze_i        (Pipe_Freeze),
        .stall_cycles_o  (stall_cycles),
        .flush_count_o   (flush_count),
        .freeze_cycles_o (freeze_cycles)
    );
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: two instances (LOAD_USE_CYCLES 1 and 3)
// share stimulus and are compared against a remaining-bubbles reference model.
module tb_hazard_detection_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] IFID_rs1, IFID_rs2, ID_rd;
    logic       ID_uses_rs1, ID_uses_rs2, ID_RegWrite, ID_MemRead;
    logic       EX_branch_taken, mem_ready, EXMEM_MemAccess;

    logic       pcw [2];
    logic       ifw [2];
    logic       fl  [2];
    logic       bub [2];
    logic       frz [2];
    logic [4:0] idrd [2];
    logic [4:0] exrd [2];
    logic [4:0] wbrd [2];
    logic       idrw [2];
    logic       exrw [2];
    logic       wbrw [2];
    logic       idmr [2];
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc [2];
    logic [31:0] fc [2];
    logic [31:0] zc [2];
    int          m_sc [2];
    int          m_fc [2];
    int          m_zc [2];
`endif

    hazard_detection_unit #(.LOAD_USE_CYCLES(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2), .ID_rd(ID_rd),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .EX_branch_taken(EX_branch_taken), .mem_ready(mem_ready),
        .EXMEM_MemAccess(EXMEM_MemAccess), .PC_Write(pcw[0]), .IFID_Write(ifw[0]),
        .IFID_Flush(fl[0]), .IDEX_Bubble(bub[0]), .Pipe_Freeze(frz[0]),
        .IDEX_rd(idrd[0]), .EXMEM_rd(exrd[0]), .MEM_WB_rd(wbrd[0]),
        .IDEX_RegWrite(idrw[0]), .EXMEM_RegWrite(exrw[0]), .MEM_WB_RegWrite(wbrw[0]),
        .IDEX_MemRead(idmr[0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc[0]), .flush_count(fc[0]), .freeze_cycles(zc[0])
`endif
    );

    hazard_detection_unit #(.LOAD_USE_CYCLES(3), .CNT_W(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2), .ID_rd(ID_rd),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .EX_branch_taken(EX_branch_taken), .mem_ready(mem_ready),
        .EXMEM_MemAccess(EXMEM_MemAccess), .PC_Write(pcw[1]), .IFID_Write(ifw[1]),
        .IFID_Flush(fl[1]), .IDEX_Bubble(bub[1]), .Pipe_Freeze(frz[1]),
        .IDEX_rd(idrd[1]), .EXMEM_rd(exrd[1]), .MEM_WB_rd(wbrd[1]),
        .IDEX_RegWrite(idrw[1]), .EXMEM_RegWrite(exrw[1]), .MEM_WB_RegWrite(wbrw[1]),
        .IDEX_MemRead(idmr[1])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc[1]), .flush_count(fc[1]), .freeze_cycles(zc[1])
`endif
    );

    // {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze,
    //  IDEX_rd, IDEX_RegWrite, IDEX_MemRead, EXMEM_rd, EXMEM_RegWrite,
    //  MEM_WB_rd, MEM_WB_RegWrite}
    logic [23:0] obs [2];
    assign obs[0] = {pcw[0], ifw[0], fl[0], bub[0], frz[0], idrd[0], idrw[0], idmr[0],
                     exrd[0], exrw[0], wbrd[0], wbrw[0]};
    assign obs[1] = {pcw[1], ifw[1], fl[1], bub[1], frz[1], idrd[1], idrw[1], idmr[1],
                     exrd[1], exrw[1], wbrd[1], wbrw[1]};

    int total = 0;
    int bad   = 0;

    // Reference model: each pipe slot holds {rd, RegWrite, MemRead};
    // m_rem counts bubbles still owed after the current cycle.
    int          luc [2] = '{1, 3};
    logic [6:0]  m_idex [2];
    logic [6:0]  m_ex   [2];
    logic [6:0]  m_wb   [2];
    int          m_rem  [2];
    logic [23:0] expv   [2];

    function automatic logic model_lu(int k);
        logic [4:0] rd;
        rd = m_idex[k][6:2];
        return m_idex[k][1] && m_idex[k][0] && (rd != 5'd0) &&
               ((ID_uses_rs1 && rd == IFID_rs1) || (ID_uses_rs2 && rd == IFID_rs2));
    endfunction

    // Controls as {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze}.
    function automatic logic [4:0] model_ctl(int k);
        if (!rst_n) return 5'b00000;
        if (EXMEM_MemAccess && !mem_ready) return 5'b00001;
        if (EX_branch_taken) return 5'b11110;
        if (m_rem[k] > 0 || model_lu(k)) return 5'b00010;
        return 5'b11000;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_idex[k] = '0; m_ex[k] = '0; m_wb[k] = '0; m_rem[k] = 0;
`ifdef HAZARD_PERF_CNT_EN
            m_sc[k] = 0; m_fc[k] = 0; m_zc[k] = 0;
`endif
        end
    endtask

    task automatic model_eval();
        for (int k = 0; k < 2; k++)
            expv[k] = {model_ctl(k), m_idex[k], m_ex[k][6:1], m_wb[k][6:2], m_wb[k][1]};
    endtask

    task automatic model_clock();
        logic [4:0] c;
        logic       lu;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_idex[k] = '0; m_ex[k] = '0; m_wb[k] = '0; m_rem[k] = 0;
            end else begin
                c  = model_ctl(k);
                lu = model_lu(k);
`ifdef HAZARD_PERF_CNT_EN
                if (c[1] && !c[2]) m_sc[k]++;
                if (c[2]) m_fc[k]++;
                if (c[0]) m_zc[k]++;
`endif
                if (c[0]) begin
                    m_wb[k] = '0;
                end else begin
                    m_wb[k]   = m_ex[k];
                    m_ex[k]   = m_idex[k];
                    m_idex[k] = c[1] ? 7'd0 : {ID_rd, ID_RegWrite, ID_MemRead};
                end
                if (EXMEM_MemAccess && !mem_ready) m_rem[k] = m_rem[k];
                else if (EX_branch_taken)         m_rem[k] = 0;
                else if (m_rem[k] > 0)            m_rem[k] = m_rem[k] - 1;
                else if (lu)                      m_rem[k] = luc[k] - 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic drive_idle();
        IFID_rs1 = 0; IFID_rs2 = 0; ID_uses_rs1 = 0; ID_uses_rs2 = 0;
        ID_rd = 0; ID_RegWrite = 0; ID_MemRead = 0;
        EX_branch_taken = 0; mem_ready = 1; EXMEM_MemAccess = 0;
    endtask

    task automatic drive_load(input logic [4:0] rd);
        drive_idle();
        ID_rd = rd; ID_RegWrite = 1; ID_MemRead = 1; ID_uses_rs1 = 1; IFID_rs1 = 5'd2;
    endtask

    // add x6, x5, x1
    task automatic drive_add_x5();
        drive_idle();
        ID_rd = 5'd6; ID_RegWrite = 1; ID_uses_rs1 = 1; ID_uses_rs2 = 1;
        IFID_rs1 = 5'd5; IFID_rs2 = 5'd1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive_idle();
        model_reset();
        #2;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== 24'd0) begin
                bad++; $display("FAIL reset_hold dut%0d got=%h want=%h", k, obs[k], 24'd0);
            end
        end
        tick();
        drive_add_x5();
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== 24'd0) begin
                bad++; $display("FAIL reset_forced dut%0d got=%h want=%h", k, obs[k], 24'd0);
            end
        end
        rst_n = 1;
        drive_idle();
        #2;
        model_eval();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== expv[k] || pcw[k] !== 1'b1) begin
                bad++; $display("FAIL reset_release dut%0d got=%h want=%h", k, obs[k], expv[k]);
            end
        end
        tick();
    endtask

    task automatic test_load_use();
        int nb;
        nb = 0;
        drive_load(5'd5);
        #2; model_eval();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== expv[k]) begin
                bad++; $display("FAIL lu_load dut%0d got=%h want=%h", k, obs[k], expv[k]);
            end
        end
        tick();
        drive_add_x5();
        #2; model_eval();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== expv[k] || {pcw[k], ifw[k], bub[k]} !== 3'b001) begin
                bad++; $display("FAIL lu_detect dut%0d got=%h want=%h", k, obs[k], expv[k]);
            end
        end
        nb += bub[1];
        tick();
        #2; model_eval();
        total++;
        if ({pcw[0], idrd[0], exrd[0]} !== {1'b1, 5'd0, 5'd5}) begin
            bad++; $display("FAIL lu1_resume got=%b/%0d/%0d want=1/0/5", pcw[0], idrd[0], exrd[0]);
        end
        for (int j = 0; j < 3; j++) begin
            if (j > 0) begin #2; model_eval(); end
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== expv[k]) begin
                    bad++; $display("FAIL lu_seq%0d dut%0d got=%h want=%h", j, k, obs[k], expv[k]);
                end
            end
            total++;
            if (bub[1] !== (j < 2)) begin
                bad++; $display("FAIL lu3_bubble%0d got=%b want=%b", j, bub[1], (j < 2));
            end
            nb += bub[1];
            tick();
        end
        total++;
        if (nb !== 3) begin
            bad++; $display("FAIL lu3_count got=%0d want=3", nb);
        end
    endtask

    task automatic test_mem_wait();
        drive_idle(); ID_rd = 5'd9; ID_RegWrite = 1;
        #2; tick();
        drive_idle(); ID_rd = 5'd10; ID_RegWrite = 1;
        #2; tick();
        for (int j = 0; j < 5; j++) begin
            drive_idle(); ID_rd = 5'd11; ID_RegWrite = 1;
            EXMEM_MemAccess = 1; mem_ready = (j == 4);
            #2; model_eval();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== expv[k] || frz[k] !== (j < 4) || exrd[k] !== 5'd9 ||
                    (j > 0 && {wbrd[k], wbrw[k]} !== 6'd0)) begin
                    bad++; $display("FAIL mem_wait%0d dut%0d got=%h want=%h", j, k, obs[k], expv[k]);
                end
            end
            tick();
        end
    endtask

    task automatic test_branch();
        drive_load(5'd5);
        #2; tick();
        drive_add_x5(); EX_branch_taken = 1;
        #2; model_eval();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== expv[k] || {pcw[k], fl[k], bub[k]} !== 3'b111) begin
                bad++; $display("FAIL branch_lu dut%0d got=%h want=%h", k, obs[k], expv[k]);
            end
        end
        tick();
        drive_idle();
        #2; model_eval();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== expv[k] || {pcw[k], bub[k]} !== 2'b10) begin
                bad++; $display("FAIL branch_run dut%0d got=%h want=%h", k, obs[k], expv[k]);
            end
        end
        tick();
    endtask

    task automatic test_x0();
        drive_load(5'd0);
        #2; tick();
        drive_idle(); ID_uses_rs1 = 1; ID_uses_rs2 = 1; ID_rd = 5'd7; ID_RegWrite = 1;
        #2; model_eval();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== expv[k] || pcw[k] !== 1'b1) begin
                bad++; $display("FAIL x0_nostall dut%0d got=%h want=%h", k, obs[k], expv[k]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drive_load(5'd5);
        #2; tick();
        drive_add_x5();
        #2; tick();
        #2;
        total++;
        if (bub[1] !== 1'b1) begin
            bad++; $display("FAIL rst_pre_stall got=%b want=1", bub[1]);
        end
        rst_n = 0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== 24'd0) begin
                bad++; $display("FAIL rst_mid dut%0d got=%h want=%h", k, obs[k], 24'd0);
            end
`ifdef HAZARD_PERF_CNT_EN
            total++;
            if ({sc[k], fc[k], zc[k]} !== 96'd0) begin
                bad++; $display("FAIL rst_perf dut%0d got=%0d/%0d/%0d want=0", k, sc[k], fc[k], zc[k]);
            end
`endif
        end
        tick();
        rst_n = 1;
        #2; model_eval();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== expv[k] || {pcw[k], bub[k]} !== 2'b10) begin
                bad++; $display("FAIL rst_run dut%0d got=%h want=%h", k, obs[k], expv[k]);
            end
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            IFID_rs1        = 5'($urandom_range(0, 3));
            IFID_rs2        = 5'($urandom_range(0, 3));
            ID_uses_rs1     = 1'($urandom_range(0, 1));
            ID_uses_rs2     = 1'($urandom_range(0, 1));
            ID_rd           = 5'($urandom_range(0, 3));
            ID_RegWrite     = ($urandom_range(0, 3) != 0);
            ID_MemRead      = ($urandom_range(0, 2) == 0);
            EX_branch_taken = ($urandom_range(0, 9) == 0);
            EXMEM_MemAccess = ($urandom_range(0, 2) == 0);
            mem_ready       = ($urandom_range(0, 3) != 0);
            #2; model_eval();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== expv[k]) begin
                    bad++; $display("FAIL rand%0d dut%0d got=%h want=%h", n, k, obs[k], expv[k]);
                end
`ifdef HAZARD_PERF_CNT_EN
                total++;
                if (sc[k] !== 32'(m_sc[k]) || fc[k] !== 32'(m_fc[k]) || zc[k] !== 32'(m_zc[k])) begin
                    bad++; $display("FAIL rand_perf%0d dut%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                                    n, k, sc[k], fc[k], zc[k], m_sc[k], m_fc[k], m_zc[k]);
                end
`endif
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch();
        test_x0();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
Producer side of the operand-forwarding path in the 5-stage RISC-V pipeline.
- Tracks destination-register state (rd, RegWrite, MemRead) through ID/EX, EX/MEM and MEM/WB. These registered fields are the inputs the Forward_Unit consumes.
- Detects hazards forwarding cannot resolve (load-use, data-memory wait, taken branch) and drives PC/IF-ID stall, flush and bubble controls.

Parameters:
LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (1..7); models data-memory read latency
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
IFID_rs1  in  5  rs1 of instruction in ID
IFID_rs2  in  5  rs2 of instruction in ID
ID_uses_rs1  in  1  ID instruction reads rs1
ID_uses_rs2  in  1  ID instruction reads rs2
ID_rd  in  5  rd of instruction in ID
ID_RegWrite  in  1  ID instruction writes rd
ID_MemRead  in  1  ID instruction is a load
EX_branch_taken  in  1  branch/jump resolved taken in EX this cycle
mem_ready  in  1  data memory completes MEM-stage access this cycle
EXMEM_MemAccess  in  1  instruction in MEM is a load/store
PC_Write  out  1  PC may update
IFID_Write  out  1  IF/ID register may load
IFID_Flush  out  1  IF/ID loads a NOP
IDEX_Bubble  out  1  ID/EX loads a bubble (controls zeroed)
Pipe_Freeze  out  1  ID/EX and EX/MEM hold; MEM/WB loads bubble
IDEX_rd, EXMEM_rd, MEM_WB_rd  out  5 each  tracked destination registers
IDEX_RegWrite, EXMEM_RegWrite, MEM_WB_RegWrite  out  1 each  tracked write enables
IDEX_MemRead  out  1  tracked load flag in EX

Behaviour:
- Reset (rst_n low, asynchronous):
  - All tracked outputs are 0; state is RUN; counter is 0.
  - While reset is asserted, PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble and Pipe_Freeze are all forced to 0.
- Hazard terms (combinational):
  - load_use = IDEX_MemRead & IDEX_RegWrite & (IDEX_rd != 0) & ((ID_uses_rs1 & IDEX_rd == IFID_rs1) | (ID_uses_rs2 & IDEX_rd == IFID_rs2)).
  - mem_wait = EXMEM_MemAccess & ~mem_ready.
- Priority, highest first:
  1. mem_wait: Pipe_Freeze=1, PC_Write=0, IFID_Write=0, Flush=0, Bubble=0. FSM state and counter hold.
  2. EX_branch_taken: PC_Write=1, IFID_Flush=1, IDEX_Bubble=1. FSM goes to RUN and counter clears, aborting any stall.
  3. Stall active (load_use in RUN, or state LU_STALL): PC_Write=0, IFID_Write=0, IDEX_Bubble=1.
  4. Otherwise: PC_Write=1, IFID_Write=1, all other controls 0.
- FSM states and transitions:
  - RUN: if load_use and no higher-priority event, the current cycle is bubble 1.
    - LOAD_USE_CYCLES=1: stay in RUN.
    - Otherwise: go to LU_STALL with counter = LOAD_USE_CYCLES-2.
  - LU_STALL: each unfrozen cycle inserts one bubble. If counter==0, go to RUN; else decrement.
- Tracking registers, on each rising edge:
  - Pipe_Freeze=1: ID/EX and EX/MEM fields hold; MEM/WB fields are cleared to 0 (bubble).
  - Otherwise: MEM/WB <= EX/MEM; EX/MEM <= ID/EX.
    - ID/EX <= 0 if IDEX_Bubble, else {ID_rd, ID_RegWrite, ID_MemRead}.
- rd==0 is tracked as given. Consumers ignore x0; load_use never fires on x0.
- Latency: every control output is Mealy, valid in the same cycle as its inputs. Tracked fields update 1 cycle after each edge.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles (CNT_W), flush_count (CNT_W), freeze_cycles (CNT_W).
  - Each counter increments once per cycle in which its output is asserted: IDEX_Bubble without flush, IFID_Flush, and Pipe_Freeze respectively.
  - Counters are saturating and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - typedef for the state enum (RUN, LU_STALL);
  - typedef for the pipe_tag struct {rd[4:0], RegWrite, MemRead};
  - constant REG_ZERO = 5'd0.
- One natural sub-module, hazard_perf_counters, instantiated only under HAZARD_PERF_CNT_EN.

Test Plan:
- Load then dependent use (lw x5; add x6,x5,x1), LOAD_USE_CYCLES=1:
  - Detection cycle: PC_Write=0, IFID_Write=0, IDEX_Bubble=1.
  - Next cycle: PC_Write=1. IDEX_rd=0 and EXMEM_rd=5 after that edge.
- LOAD_USE_CYCLES=3 with the same pair -> exactly 3 consecutive bubble cycles, then RUN.
- mem_ready=0 for 4 cycles with EXMEM_MemAccess=1 -> Pipe_Freeze=1 for 4 cycles; EXMEM_rd holds; MEM_WB_rd=0, MEM_WB_RegWrite=0.
- EX_branch_taken=1 in the same cycle as load_use -> IFID_Flush=1, IDEX_Bubble=1, PC_Write=1; state RUN next cycle.
- Load with rd=x0 followed by a use of x0 -> no stall; PC_Write stays 1.
- rst_n dropped mid-LU_STALL -> all outputs 0 immediately; state RUN after release; perf counters 0.
